clk_freq_monitor: RTL and testbench

- Checker on the receiving side of the divided clock. It samples the 3.125 MHz output of the frequency scaler in the clk_50M domain and measures the high and low phases of every period.
- Declares lock after a run of correct periods; flags wrong duty/period and stuck-clock conditions.
- Provides registered edge strobes so downstream logic can use clock-enables in the clk_50M domain instead of clocking from the divided clock.

---
 rtl/freq_scaling_pkg.sv | 21 ++
 rtl/clk_freq_monitor_if.sv | 29 ++
 rtl/edge_detect_sync.sv | 30 +++
 rtl/clk_freq_monitor.sv | 147 ++++++++++++++
 tb/tb_clk_freq_monitor.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_scaling_pkg.sv
// Shared definitions for the divided-clock generator and its receive-side monitor.
package freq_scaling_pkg;

  // Monitor tracking state
  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } mon_state_e;

  // Nominal 50 MHz -> 3.125 MHz division: 8 cycles high, 8 cycles low
  localparam int EXP_HIGH_DEF = 8;
  localparam int EXP_LOW_DEF  = 8;
  localparam int DIV_RATIO    = 16;

  // Bits needed to hold 0..max_val (at least 1)
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/clk_freq_monitor_if.sv
// Divided-clock input and measurement/status outputs of the frequency monitor.
interface clk_freq_monitor_if #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 16
);
  logic             clk_in;
  logic             rise_strobe;
  logic             fall_strobe;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_high;
  logic [CNT_W-1:0] meas_low;
  logic             period_err;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  // Monitor side
  modport master (
    input  clk_in,
    output rise_strobe, fall_strobe, meas_valid, meas_high, meas_low,
           period_err, locked, err_count
  );

  // Consumer side (also owns the divided clock it feeds in)
  modport slave (
    output clk_in,
    input  rise_strobe, fall_strobe, meas_valid, meas_high, meas_low,
           period_err, locked, err_count
  );
endinterface

// File: rtl/edge_detect_sync.sv
// Edge detector for a level already synchronous to clk_50M.
// rise/fall are combinational for the same-cycle datapath; the strobes are
// their registered copies for downstream clock-enables.
module edge_detect_sync (
  input  logic clk_50M,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic rise_strobe,
  output logic fall_strobe
);
  logic prev;

  assign rise = d & ~prev;
  assign fall = ~d & prev;

  // Previous sample and registered one-cycle edge strobes
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      prev        <= 1'b0;
      rise_strobe <= 1'b0;
      fall_strobe <= 1'b0;
    end else begin
      prev        <= d;
      rise_strobe <= rise;
      fall_strobe <= fall;
    end
  end
endmodule

// File: rtl/clk_freq_monitor.sv
// Receive-side checker for the divided clock: measures each period's high and
// low phase in clk_50M cycles, declares lock after a run of exact periods and
// flags bad periods and stuck clocks.
module clk_freq_monitor
  import freq_scaling_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int EXP_HIGH   = EXP_HIGH_DEF,
  parameter int EXP_LOW    = EXP_LOW_DEF,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 64,
  parameter int ERR_W      = 16
) (
  input logic                clk_50M,
  input logic                reset,
  clk_freq_monitor_if.master mon
);
  localparam int GOOD_W = cnt_width(LOCK_COUNT);
  localparam int IDLE_W = cnt_width(TIMEOUT);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  EXP_HI_C  = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0]  EXP_LO_C  = CNT_W'(EXP_LOW);
  localparam logic [GOOD_W-1:0] GOOD_SAT  = GOOD_W'(LOCK_COUNT);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'((LOCK_COUNT > 0) ? LOCK_COUNT - 1 : 0);
  localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;
  // A TIMEOUT of 0 disables stuck-clock detection, so a rise always wins
  localparam bit                TO_EN     = (TIMEOUT > 0);

  logic              rise, fall, edge_any, timeout;
  mon_state_e        state_q, state_d;
  logic [CNT_W-1:0]  hi_cnt, lo_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic              tracking, period_good, meas_take, err_evt;

  edge_detect_sync u_edge (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .d           (mon.clk_in),
    .rise        (rise),
    .fall        (fall),
    .rise_strobe (mon.rise_strobe),
    .fall_strobe (mon.fall_strobe)
  );

  assign edge_any = rise | fall;
  // Fires on the cycle the idle count would reach TIMEOUT; the count then
  // parks at TIMEOUT so the event cannot repeat until an edge clears it.
  assign timeout  = TO_EN && !edge_any && (idle_cnt == IDLE_LAST);

  // Cycles since the last edge, saturating at TIMEOUT
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset)                    idle_cnt <= '0;
    else if (edge_any)            idle_cnt <= '0;
    else if (idle_cnt != IDLE_SAT) idle_cnt <= idle_cnt + 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) state_q <= SEEK;
    else       state_q <= state_d;
  end

  // FSM next state; a rise clears the idle count, so it can never coincide with a timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEEK:   if (rise) state_d = TRACK;
      TRACK:  begin
        if (rise) begin
          if (period_good && good_cnt >= GOOD_LAST) state_d = LOCKED;
        end else if (timeout) begin
          state_d = SEEK;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (!period_good) state_d = TRACK;
        end else if (timeout) begin
          state_d = SEEK;
        end
      end
      default: state_d = SEEK;
    endcase
  end

  // FSM outputs: period qualification and error events
  always_comb begin
    tracking    = (state_q != SEEK);
    period_good = (hi_cnt == EXP_HI_C) && (lo_cnt == EXP_LO_C);
    meas_take   = tracking && rise;
    err_evt     = tracking && ((rise && !period_good) || timeout);
  end

  // Phase counters; the rise sample already belongs to the new high phase
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else if (rise) begin
      hi_cnt <= CNT_W'(1);
      lo_cnt <= '0;
    end else if (!tracking) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else if (mon.clk_in) begin
      if (hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + 1'b1;
    end else begin
      if (lo_cnt != CNT_MAX) lo_cnt <= lo_cnt + 1'b1;
    end
  end

  // Run length of consecutive exact periods; restarts on every fresh acquisition
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      good_cnt <= '0;
    end else if (rise) begin
      if (!tracking || !period_good) good_cnt <= '0;
      else if (good_cnt != GOOD_SAT) good_cnt <= good_cnt + 1'b1;
    end
  end

  // Registered measurement, status and saturating error total
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      mon.meas_valid <= 1'b0;
      mon.meas_high  <= '0;
      mon.meas_low   <= '0;
      mon.period_err <= 1'b0;
      mon.locked     <= 1'b0;
      mon.err_count  <= '0;
    end else begin
      mon.meas_valid <= meas_take;
      if (meas_take) begin
        mon.meas_high <= hi_cnt;
        mon.meas_low  <= lo_cnt;
      end
      mon.period_err <= err_evt;
      mon.locked     <= (state_d == LOCKED);
      if (err_evt && mon.err_count != ERR_MAX) mon.err_count <= mon.err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Scoreboard bench for clk_freq_monitor: two instances share one clk_in stream
// (default build, and one with a long timeout and a 2-bit error counter).
module tb_clk_freq_monitor;

  typedef struct packed {
    int t;
    bit r;
    bit f;
    bit mv;
    bit pe;
    bit lk;
    int mh;
    int ml;
    int ec;
  } ev_t;

  localparam int TO   [2] = '{64, 1000};
  localparam int EMAX [2] = '{65535, 3};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_in = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  q0[$];
  ev_t  q1[$];

  // Reference model state: times of the last edges, tracking flag, good-run length
  int m_prev[2], m_le[2], m_lr[2], m_lf[2], m_trk[2], m_run[2], m_err[2], m_mh[2], m_ml[2];

  clk_freq_monitor_if #(.CNT_W(8), .ERR_W(16)) if0 ();
  clk_freq_monitor_if #(.CNT_W(8), .ERR_W(2))  if1 ();
  assign if0.clk_in = clk_in;
  assign if1.clk_in = clk_in;

  clk_freq_monitor #(.CNT_W(8), .EXP_HIGH(8), .EXP_LOW(8), .LOCK_COUNT(4), .TIMEOUT(64), .ERR_W(16))
    dut0 (.clk_50M(clk), .reset(reset), .mon(if0.master));
  clk_freq_monitor #(.CNT_W(8), .EXP_HIGH(8), .EXP_LOW(8), .LOCK_COUNT(4), .TIMEOUT(1000), .ERR_W(2))
    dut1 (.clk_50M(clk), .reset(reset), .mon(if1.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset(input int i, input int t0);
    m_prev[i] = 0; m_le[i] = t0 - 1; m_lr[i] = 0; m_lf[i] = 0;
    m_trk[i] = 0; m_run[i] = 0; m_err[i] = 0; m_mh[i] = 0; m_ml[i] = 0;
  endtask

  // One clk_in sample at time t; phases come from edge-time differences
  task automatic model_step(input int i, input bit v, input int t, output ev_t e, output bit has);
    bit rise, fall, mv, pe;
    int hi, lo;
    rise = v && (m_prev[i] == 0);
    fall = !v && (m_prev[i] != 0);
    mv = 0; pe = 0;
    if (rise) begin
      if (m_trk[i] != 0) begin
        hi = m_lf[i] - m_lr[i]; if (hi > 255) hi = 255;
        lo = t - m_lf[i];       if (lo > 255) lo = 255;
        m_mh[i] = hi; m_ml[i] = lo; mv = 1;
        if (hi == 8 && lo == 8) m_run[i]++;
        else begin m_run[i] = 0; pe = 1; end
      end else begin
        m_trk[i] = 1; m_run[i] = 0;
      end
      m_lr[i] = t;
    end else if (!fall && (t - m_le[i] == TO[i]) && m_trk[i] != 0) begin
      pe = 1; m_trk[i] = 0; m_run[i] = 0;
    end
    if (fall) m_lf[i] = t;
    if (rise || fall) m_le[i] = t;
    m_prev[i] = v;
    if (pe && m_err[i] < EMAX[i]) m_err[i]++;
    e.t = t; e.r = rise; e.f = fall; e.mv = mv; e.pe = pe;
    e.lk = (m_trk[i] != 0) && (m_run[i] >= 4);
    e.mh = m_mh[i]; e.ml = m_ml[i]; e.ec = m_err[i];
    has = rise | fall | mv | pe;
  endtask

  task automatic step_models(input bit v);
    ev_t e;
    bit  has;
    model_step(0, v, cyc + 1, e, has); if (has) q0.push_back(e);
    model_step(1, v, cyc + 1, e, has); if (has) q1.push_back(e);
  endtask

  task automatic drive(input bit v);
    @(negedge clk);
    clk_in = v;
    step_models(v);
  endtask

  task automatic hold(input bit v, input int n);
    repeat (n) drive(v);
  endtask

  task automatic period(input int h, input int l);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags0"}, int'({if0.rise_strobe, if0.fall_strobe, if0.meas_valid, if0.period_err, if0.locked}), 0);
    chk({tag, "_meas0"},  int'({if0.meas_high, if0.meas_low}), 0);
    chk({tag, "_err0"},   int'(if0.err_count), 0);
    chk({tag, "_flags1"}, int'({if1.rise_strobe, if1.fall_strobe, if1.meas_valid, if1.period_err, if1.locked}), 0);
    chk({tag, "_meas1"},  int'({if1.meas_high, if1.meas_low}), 0);
    chk({tag, "_err1"},   int'(if1.err_count), 0);
  endtask

  // Release at a negedge and present the first post-reset sample in the same step
  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    clk_in = 1'b0;
    model_reset(0, cyc + 1);
    model_reset(1, cyc + 1);
    step_models(1'b0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    q0.delete();
    q1.delete();
    #1 chk_zero("async_rst");
    release_reset();
  endtask

  // Monitor: compare every cycle in which either side shows activity
  task automatic score(input int i, input ev_t a);
    ev_t e;
    bit  due, any;
    any = a.r | a.f | a.mv | a.pe;
    due = 0;
    e = '0;
    if (i == 0 && q0.size() > 0 && q0[0].t <= cyc) begin e = q0.pop_front(); due = 1; end
    if (i == 1 && q1.size() > 0 && q1[0].t <= cyc) begin e = q1.pop_front(); due = 1; end
    if (any || due) begin
      checks++;
      if (!due) begin
        errors++;
        $display("FAIL ev%0d unexpected at cyc %0d: r%0b f%0b mv%0b pe%0b lk%0b mh=%0d ml=%0d ec=%0d",
                 i, cyc, a.r, a.f, a.mv, a.pe, a.lk, a.mh, a.ml, a.ec);
      end else if (a != e) begin
        errors++;
        $display("FAIL ev%0d cyc %0d got r%0b f%0b mv%0b pe%0b lk%0b mh=%0d ml=%0d ec=%0d; want t=%0d r%0b f%0b mv%0b pe%0b lk%0b mh=%0d ml=%0d ec=%0d",
                 i, cyc, a.r, a.f, a.mv, a.pe, a.lk, a.mh, a.ml, a.ec,
                 e.t, e.r, e.f, e.mv, e.pe, e.lk, e.mh, e.ml, e.ec);
      end
    end
  endtask

  always @(negedge clk) begin
    ev_t a0, a1;
    if (!reset) begin
      a0.t = cyc; a0.r = if0.rise_strobe; a0.f = if0.fall_strobe; a0.mv = if0.meas_valid;
      a0.pe = if0.period_err; a0.lk = if0.locked; a0.mh = int'(if0.meas_high);
      a0.ml = int'(if0.meas_low); a0.ec = int'(if0.err_count);
      a1.t = cyc; a1.r = if1.rise_strobe; a1.f = if1.fall_strobe; a1.mv = if1.meas_valid;
      a1.pe = if1.period_err; a1.lk = if1.locked; a1.mh = int'(if1.meas_high);
      a1.ml = int'(if1.meas_low); a1.ec = int'(if1.err_count);
      score(0, a0);
      score(1, a1);
    end
  end

  initial begin
    int r, h, l;
    reset = 1'b1;
    clk_in = 1'b0;
    @(posedge clk);
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    release_reset();

    // Clean 8/8 stream: first rise 3 cycles after release, lock at the 5th rise
    hold(1'b0, 2);
    repeat (6) period(8, 8);
    chk("lock_clean", int'(if0.locked), 1);
    chk("err_clean", int'(if0.err_count), 0);

    // One stretched high phase, then relock
    period(9, 8);
    repeat (5) period(8, 8);
    chk("relock_stretch", int'(if0.locked), 1);
    chk("err_stretch", int'(if0.err_count), 1);

    // Low held past the timeout, then reacquire
    hold(1'b1, 8);
    hold(1'b0, 70);
    repeat (6) period(8, 8);
    chk("relock_timeout", int'(if0.locked), 1);
    chk("err_timeout", int'(if0.err_count), 2);

    // High held past counter saturation; single timeout error on dut0
    hold(1'b1, 300);
    hold(1'b0, 8);
    period(8, 8);
    chk("meas_high_sat", int'(if1.meas_high), 255);
    chk("err_stuck_once", int'(if0.err_count), 3);

    // Reset while locked, mid high phase
    repeat (5) period(8, 8);
    chk("locked_before_rst", int'(if0.locked), 1);
    hold(1'b1, 4);
    mid_reset();
    hold(1'b0, 2);
    repeat (4) period(8, 8);
    chk("no_lock_4th_rise", int'(if0.locked), 0);
    period(8, 8);
    chk("lock_5th_rise", int'(if0.locked), 1);

    // Five bad periods: 2-bit counter saturates
    repeat (5) period(7, 8);
    period(8, 8);
    chk("err_sat_w2", int'(if1.err_count), 3);
    chk("err_5bad", int'(if0.err_count), 5);

    // Randomized mix of good, bad and stuck periods
    repeat (150) begin
      r = $urandom_range(0, 19);
      if (r < 12)       begin h = 8;  l = 8;  end
      else if (r < 17)  begin h = $urandom_range(1, 12); l = $urandom_range(1, 12); end
      else if (r == 17) begin h = 8;  l = 70; end
      else if (r == 18) begin h = 70; l = 8;  end
      else              begin h = 9;  l = 8;  end
      period(h, l);
    end

    hold(1'b0, 4);
    @(negedge clk);
    @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
